mem_access_stage: RTL and testbench

//  EX/MEM pipeline register plus load/store unit. Captures ALUResult_ex/MemWriteData_ex from EX,

---
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   EX/MEM pipeline register plus load/store unit. Captures the EX-stage
//   result and store data, runs a req/ready data-memory access with byte
//   lanes, and aligns/extends load data for write-back. Stalls IF/ID/EX
//   while an access is outstanding.
//
// Parameters
//   TIMEOUT  max ACCESS cycles awaiting dmem_ready before a bus error (0 = none)
//
// Optional feature
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are not
//                     issued; MisalignErr_mem pulses and RegWrite_mem is
//                     cleared. When undefined, low address bits are ignored.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   ALUResult_ex/MemWriteData_ex       EX result (address) / store data
//   rdAddr_ex/RegWrite_ex/MemtoReg_ex  write-back control from EX
//   MemRead_ex/MemWrite_ex             load / store
//   MemSize_ex/MemUnsigned_ex          access size, zero-extend load
//   ALUResult_mem/rdAddr_mem/RegWrite_mem/MemtoReg_mem  registered to WB/fwd
//   LoadData_mem                       aligned, extended load data
//   Stall_mem                          hold IF/ID/EX (state == ACCESS)
//   BusErr_mem/MisalignErr_mem         1-cycle error pulses
//   dmem_req/we/addr/be/wdata          data-memory request
//   dmem_ready/dmem_rdata              data-memory response
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemSize_ex,
  input  logic        MemUnsigned_ex,
  input  logic        MemtoReg_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemtoReg_mem,
  output logic [31:0] LoadData_mem,
  output logic        Stall_mem,
  output logic        BusErr_mem,
  output logic        MisalignErr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_memtoreg;
  logic [31:0] r_load;
  logic        r_buserr;

  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load;
  logic        w_trap;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap = ((MemSize_ex == 2'b01) && ALUResult_ex[0]) ||
                  (MemSize_ex[1] && (ALUResult_ex[1:0] != 2'b00));
  assign MisalignErr_mem = r_misalign;
`else
  assign w_trap = 1'b0;
  assign MisalignErr_mem = 1'b0;
`endif

  assign w_a = r_alu[1:0];

  // Half uses only a[1] and word ignores a, so misaligned bits are dropped
  // when the trap is not built in.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_a[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign w_rbyte = dmem_rdata[{w_a, 3'b000} +: 8];
  assign w_rhalf = dmem_rdata[{w_a[1], 4'b0000} +: 16];

  always_comb begin
    w_load = dmem_rdata;
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_rbyte[7]}}, w_rbyte};
      2'b01:   w_load = {{16{~r_unsigned & w_rhalf[15]}}, w_rhalf};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_alu      <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_memtoreg <= 1'b0;
      r_load     <= '0;
      r_buserr   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_buserr <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      if (r_state == S_ACCESS) begin
        if (dmem_ready) begin
          r_state <= S_DONE;
          if (r_memread) r_load <= w_load;
        end else if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1)) begin
          r_state    <= S_DONE;
          r_buserr   <= 1'b1;
          r_regwrite <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_alu      <= ALUResult_ex;
        r_wdata    <= MemWriteData_ex;
        r_rd       <= rdAddr_ex;
        r_regwrite <= RegWrite_ex & ~w_trap;
        r_memread  <= MemRead_ex;
        r_memwrite <= MemWrite_ex;
        r_size     <= MemSize_ex;
        r_unsigned <= MemUnsigned_ex;
        r_memtoreg <= MemtoReg_ex;
        r_cnt      <= '0;
        r_state    <= ((MemRead_ex | MemWrite_ex) && !w_trap) ? S_ACCESS : S_IDLE;
`ifdef MISALIGN_TRAP_EN
        r_misalign <= (MemRead_ex | MemWrite_ex) & w_trap;
`endif
      end
    end
  end

  assign ALUResult_mem = r_alu;
  assign rdAddr_mem    = r_rd;
  assign RegWrite_mem  = r_regwrite;
  assign MemtoReg_mem  = r_memtoreg;
  assign LoadData_mem  = r_load;
  assign BusErr_mem    = r_buserr;
  assign Stall_mem     = (r_state == S_ACCESS);

  // Lane enables are zeroed for non-memory ops so the port reads 0 after reset.
  assign dmem_req   = (r_state == S_ACCESS);
  assign dmem_we    = (r_state == S_ACCESS) & r_memwrite;
  assign dmem_addr  = {r_alu[31:2], 2'b00};
  assign dmem_be    = w_be & {4{r_memread | r_memwrite}};
  assign dmem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUResult_ex;
  logic [31:0] MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex;
  logic        MemRead_ex;
  logic        MemWrite_ex;
  logic [1:0]  MemSize_ex;
  logic        MemUnsigned_ex;
  logic        MemtoReg_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic        MemtoReg_mem;
  logic [31:0] LoadData_mem;
  logic        Stall_mem;
  logic        BusErr_mem;
  logic        MisalignErr_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemSize_ex(MemSize_ex), .MemUnsigned_ex(MemUnsigned_ex),
    .MemtoReg_ex(MemtoReg_ex),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
    .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .LoadData_mem(LoadData_mem), .Stall_mem(Stall_mem),
    .BusErr_mem(BusErr_mem), .MisalignErr_mem(MisalignErr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic uns, input logic m2r);
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
    rdAddr_ex       = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemSize_ex      = sz;
    MemUnsigned_ex  = uns;
    MemtoReg_ex     = m2r;
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    nop();
    #13;
    check("rst_stall", {31'b0, Stall_mem}, 32'd0);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_be", {28'b0, dmem_be}, 32'd0);
    check("rst_alu", ALUResult_mem, 32'd0);
    check("rst_load", LoadData_mem, 32'd0);
    check("rst_regwrite", {31'b0, RegWrite_mem}, 32'd0);
    rst_n = 1'b1;

    // sw 0xDEADBEEF @0x100, ready in 3rd ACCESS cycle
    issue(32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step();
    nop();
    check("sw_req", {31'b0, dmem_req}, 32'd1);
    check("sw_we", {31'b0, dmem_we}, 32'd1);
    check("sw_be", {28'b0, dmem_be}, 32'hF);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_stall1", {31'b0, Stall_mem}, 32'd1);
    step();
    check("sw_stall2", {31'b0, Stall_mem}, 32'd1);
    step();
    check("sw_stall3", {31'b0, Stall_mem}, 32'd1);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check("sw_done_stall", {31'b0, Stall_mem}, 32'd0);
    check("sw_done_req", {31'b0, dmem_req}, 32'd0);
    step();

    // lb @0x103, rdata 0x80FF0000
    issue(32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step();
    nop();
    check("lb_be", {28'b0, dmem_be}, 32'h8);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_we", {31'b0, dmem_we}, 32'd0);
    check("lb_regwrite", {31'b0, RegWrite_mem}, 32'd1);
    check("lb_alu", ALUResult_mem, 32'h103);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF0000;
    step();
    dmem_ready = 1'b0;
    check("lb_data", LoadData_mem, 32'hFFFFFF80);
    check("lb_done_stall", {31'b0, Stall_mem}, 32'd0);

    // lbu @0x103 issued straight from DONE
    issue(32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step();
    nop();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check("lbu_data", LoadData_mem, 32'h00000080);

    // lhu @0x102
    issue(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    nop();
    check("lhu_be", {28'b0, dmem_be}, 32'hC);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check("lhu_data", LoadData_mem, 32'h000080FF);

    // sh 0x1234 @0x102 (upper store bits must not reach the lanes)
    issue(32'h102, 32'hABCD1234, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    step();
    nop();
    check("sh_be", {28'b0, dmem_be}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'h12341234);
    check("sh_addr", dmem_addr, 32'h100);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;

    // non-memory op passes through in one cycle
    issue(32'h55AA, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    step();
    nop();
    check("alu_result", ALUResult_mem, 32'h55AA);
    check("alu_rd", {27'b0, rdAddr_mem}, 32'd7);
    check("alu_regwrite", {31'b0, RegWrite_mem}, 32'd1);
    check("alu_stall", {31'b0, Stall_mem}, 32'd0);
    check("alu_req", {31'b0, dmem_req}, 32'd0);
    check("alu_load_kept", LoadData_mem, 32'h000080FF);
    step();

    // timeout: lw @0x200 with ready held low
    issue(32'h200, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    step();
    nop();
    n = 0;
    while (Stall_mem && n < 40) begin
      n++;
      if (BusErr_mem) check("to_early_buserr", {31'b0, BusErr_mem}, 32'd0);
      step();
    end
    check("to_cycles", n, 32'd16);
    check("to_buserr", {31'b0, BusErr_mem}, 32'd1);
    check("to_regwrite", {31'b0, RegWrite_mem}, 32'd0);
    check("to_stall", {31'b0, Stall_mem}, 32'd0);
    step();
    check("to_buserr_pulse", {31'b0, BusErr_mem}, 32'd0);

    // async reset in the 2nd ACCESS cycle
    issue(32'h300, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step();
    step();
    check("rst5_req_before", {31'b0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst5_req", {31'b0, dmem_req}, 32'd0);
    check("rst5_stall", {31'b0, Stall_mem}, 32'd0);
    check("rst5_alu", ALUResult_mem, 32'd0);
    check("rst5_be", {28'b0, dmem_be}, 32'd0);
    check("rst5_load", LoadData_mem, 32'd0);
    nop();
    #2;
    rst_n = 1'b1;
    step();
    check("rst5_idle_req", {31'b0, dmem_req}, 32'd0);
    check("rst5_idle_stall", {31'b0, Stall_mem}, 32'd0);

    // lw @0x101
    issue(32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    step();
    nop();
`ifdef MISALIGN_TRAP_EN
    check("mis_req", {31'b0, dmem_req}, 32'd0);
    check("mis_err", {31'b0, MisalignErr_mem}, 32'd1);
    check("mis_regwrite", {31'b0, RegWrite_mem}, 32'd0);
    check("mis_stall", {31'b0, Stall_mem}, 32'd0);
    step();
    check("mis_err_pulse", {31'b0, MisalignErr_mem}, 32'd0);
`else
    check("mis_req", {31'b0, dmem_req}, 32'd1);
    check("mis_addr", dmem_addr, 32'h100);
    check("mis_be", {28'b0, dmem_be}, 32'hF);
    check("mis_err", {31'b0, MisalignErr_mem}, 32'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    step();
    dmem_ready = 1'b0;
    check("mis_data", LoadData_mem, 32'h11223344);
    check("mis_regwrite", {31'b0, RegWrite_mem}, 32'd1);
`endif
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
